// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle MIPS core: controller states, ALU codes,
// opcode/funct values and the controller's datapath-control payload.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned ALUOP_W  = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC, S_ALUWB,
        S_IEXEC, S_IWB, S_BEQ, S_BNE, S_JUMP, S_JAL, S_JALWB, S_JR
    } ctrl_state_t;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_AND  = 4'h0,
        ALU_OR   = 4'h1,
        ALU_ADD  = 4'h2,
        ALU_XOR  = 4'h3,
        ALU_SUB  = 4'h6,
        ALU_SLT  = 4'h7,
        ALU_SLTU = 4'h8,
        ALU_NE   = 4'h9,
        ALU_NOR  = 4'hC
    } alu_op_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] F_JR   = 6'h08;
    localparam logic [FUNCT_W-1:0] F_ADD  = 6'h20;
    localparam logic [FUNCT_W-1:0] F_ADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] F_SUB  = 6'h22;
    localparam logic [FUNCT_W-1:0] F_SUBU = 6'h23;
    localparam logic [FUNCT_W-1:0] F_AND  = 6'h24;
    localparam logic [FUNCT_W-1:0] F_OR   = 6'h25;
    localparam logic [FUNCT_W-1:0] F_XOR  = 6'h26;
    localparam logic [FUNCT_W-1:0] F_NOR  = 6'h27;
    localparam logic [FUNCT_W-1:0] F_SLT  = 6'h2A;
    localparam logic [FUNCT_W-1:0] F_SLTU = 6'h2B;

    typedef struct packed {
        logic        iord;
        logic        alu_src_a;
        logic [2:0]  alu_src_b;
        alu_op_t     alu_op;
        logic [1:0]  pc_src;
        logic [1:0]  mem_to_reg;
        logic [1:0]  reg_dst;
        logic        ir_write;
        logic        pc_write;
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        branch_ctrl;
        logic        illegal;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALU operation decode; valid_c drops for functs the core
// does not implement.
module alu_decoder
    import cpu_pkg::*;
(
    input  logic [FUNCT_W-1:0] funct_i,
    output alu_op_t            alu_op_c,
    output logic               valid_c
);

    always_comb begin
        alu_op_c = ALU_ADD;
        valid_c  = 1'b1;
        case (funct_i)
            F_ADD, F_ADDU: alu_op_c = ALU_ADD;
            F_SUB, F_SUBU: alu_op_c = ALU_SUB;
            F_AND:         alu_op_c = ALU_AND;
            F_OR:          alu_op_c = ALU_OR;
            F_XOR:         alu_op_c = ALU_XOR;
            F_NOR:         alu_op_c = ALU_NOR;
            F_SLT:         alu_op_c = ALU_SLT;
            F_SLTU:        alu_op_c = ALU_SLTU;
            default:       valid_c  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: one state per clk_en pulse,
// Moore datapath selects, write strobes qualified by clk_en and reset.
module multicycle_ctrl
    import cpu_pkg::*;
(
    input  logic                clk_100M,
    input  logic                rst,
    input  logic                clk_en,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    output logic                IorD,
    output logic                AluSrcA,
    output logic [2:0]          AluSrcB,
    output logic [ALUOP_W-1:0]  AluOp,
    output logic [1:0]          PCSrc,
    output logic [1:0]          MemtoReg,
    output logic [1:0]          RegDst,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                RegWrite,
    output logic                MemWrite,
    output logic                Branch,
    output logic                BranchCtrl,
    output logic                illegal,
    output logic [STATE_W-1:0]  state
);

    ctrl_state_t state_q, state_d;
    ctrl_t       ctrl;
    alu_op_t     funct_op;
    logic        funct_ok;

    alu_decoder u_alu_decoder (
        .funct_i  (funct),
        .alu_op_c (funct_op),
        .valid_c  (funct_ok)
    );

    always_ff @(posedge clk_100M) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ctrl           = '0;
        ctrl.alu_op    = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ctrl.alu_src_b = 3'b001;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                state_d        = S_DECODE;
            end
            S_DECODE: begin
                // Branch target PC+4+(imm<<2) lands in AluOut for BEQ/BNE.
                ctrl.alu_src_b = 3'b011;
                case (opcode)
                    OP_LW, OP_SW:                state_d = S_MEMADR;
                    OP_RTYPE:                    state_d = (funct == F_JR) ? S_JR : S_EXEC;
                    OP_BEQ:                      state_d = S_BEQ;
                    OP_BNE:                      state_d = S_BNE;
                    OP_ADDI, OP_ADDIU, OP_SLTI:  state_d = S_IEXEC;
                    OP_J:                        state_d = S_JUMP;
                    OP_JAL:                      state_d = S_JAL;
                    default: begin
                        state_d      = S_FETCH;
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 3'b010;
                state_d        = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
                state_d   = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 2'b01;
                ctrl.reg_write  = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                state_d        = S_FETCH;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = funct_op;
                if (funct_ok) begin
                    state_d = S_ALUWB;
                end else begin
                    state_d      = S_FETCH;
                    ctrl.illegal = 1'b1;
                end
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 2'b01;
                ctrl.reg_write = 1'b1;
                state_d        = S_FETCH;
            end
            S_IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 3'b010;
                ctrl.alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_d        = S_IWB;
            end
            S_IWB: begin
                ctrl.reg_write = 1'b1;
                state_d        = S_FETCH;
            end
            S_BEQ, S_BNE: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_op      = (state_q == S_BNE) ? ALU_NE : ALU_SUB;
                ctrl.branch      = 1'b1;
                ctrl.branch_ctrl = (state_q == S_BNE);
                ctrl.pc_src      = 2'b01;
                state_d          = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_src   = 2'b10;
                ctrl.pc_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                // PC+4 passes through the ALU into AluOut while PC takes the target.
                ctrl.alu_src_b = 3'b100;
                ctrl.pc_src    = 2'b10;
                ctrl.pc_write  = 1'b1;
                state_d        = S_JALWB;
            end
            S_JALWB: begin
                ctrl.reg_dst   = 2'b10;
                ctrl.reg_write = 1'b1;
                state_d        = S_FETCH;
            end
            S_JR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 3'b100;
                ctrl.pc_write  = 1'b1;
                state_d        = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // While in reset the datapath sees FETCH selects and no strobes.
        if (!rst) begin
            ctrl           = '0;
            ctrl.alu_op    = ALU_ADD;
            ctrl.alu_src_b = 3'b001;
        end
    end

    assign IorD       = ctrl.iord;
    assign AluSrcA    = ctrl.alu_src_a;
    assign AluSrcB    = ctrl.alu_src_b;
    assign AluOp      = ctrl.alu_op;
    assign PCSrc      = ctrl.pc_src;
    assign MemtoReg   = ctrl.mem_to_reg;
    assign RegDst     = ctrl.reg_dst;
    assign BranchCtrl = ctrl.branch_ctrl;
    assign IRWrite    = ctrl.ir_write  & clk_en;
    assign PCWrite    = ctrl.pc_write  & clk_en;
    assign RegWrite   = ctrl.reg_write & clk_en;
    assign MemWrite   = ctrl.mem_write & clk_en;
    assign Branch     = ctrl.branch    & clk_en;
    assign illegal    = ctrl.illegal   & clk_en;
    assign state      = state_q;

endmodule
